rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for a shared N:1 data-select path. Accepts valid/ready requests
//  from NUM_REQ sources, grants one per cycle in rotating priority and drives the select index of an
//  internal parametric_mux. Registers the selected word into a one-entry output stage.
//  Sits between multiple producers (e.g. LSU/fetch/debug ports) and a single shared consumer port.
// PARAMETERS
//  DATA_W   32  width of each requester's data word
//  NUM_REQ  4   number of requesters; legal range 2..16
//  ID_W     $clog2(NUM_REQ)  width of grant index (derived, not overridden)
// PORTS
//  clk         in   1               clock; all state updates on rising edge
//  reset       in   1               synchronous, active-high reset
//  req_valid   in   NUM_REQ         per-requester valid
//  req_data    in   DATA_W*NUM_REQ  packed data, requester i at [(i+1)*DATA_W-1 : i*DATA_W]
//  req_ready   out  NUM_REQ         one-hot accept strobe (combinational), at most one bit set
//  req_lock    in   NUM_REQ         per-requester lock request (present only with RR_ARB_LOCK_EN)
//  out_valid   out  1               output stage holds a word
//  out_ready   in   1               consumer accepts output word
//  out_data    out  DATA_W          registered selected word
//  out_id      out  ID_W            index of requester that supplied out_data
// BEHAVIOUR
//  - Reset (reset=1 at clk edge): out_valid=0, out_data=0, out_id=0, last_grant=NUM_REQ-1 (req 0 first),
//    state=S_EMPTY, lock_active=0. req_ready=0 while reset asserted. Reset mid-transfer drops held word.
//  - States: S_EMPTY (out_valid=0), S_FULL (out_valid=1). can_accept = S_EMPTY | (S_FULL & out_ready).
//  - Arbitration (combinational): scan req_valid from (last_grant+1) mod NUM_REQ upward with wrap;
//    first set bit is winner. req_ready[winner]=can_accept & |req_valid; all other bits 0.
//  - Accept (req_valid[w] & req_ready[w]): next cycle out_data=req_data[w] via mux, out_id=w,
//    out_valid=1, last_grant=w. Latency request->out_valid: 1 cycle. Throughput: 1 word/cycle.
//  - S_FULL & out_ready & no request -> S_EMPTY; S_FULL & !out_ready -> hold out_data/out_id stable,
//    req_ready=0. S_EMPTY & no request -> stay.
//  - Simultaneous out_ready and new accept: output is replaced, stays S_FULL, no bubble.
//  - last_grant wraps NUM_REQ-1 -> 0. Only changes on accept; a stall never rotates priority.
//  - Requester may drop req_valid while not accepted; arbiter must not assume stability.
//  - ID_W index arithmetic is modulo NUM_REQ (not 2**ID_W) for non-power-of-2 NUM_REQ.
// CONFIGURATION
//  RR_ARB_LOCK_EN defined: req_lock port exists. Accept with req_lock[w]=1 sets lock_active=1, owner=w;
//   while lock_active only owner is eligible (others see req_ready=0 even if owner idle). Owner's next
//   accept with req_lock[w]=0 clears lock_active after that transfer. Reset clears lock.
//  RR_ARB_LOCK_EN undefined: no req_lock port, no lock state; pure round-robin as above.
// STRUCTURE
//  - Package rr_arb_pkg: typedef enum logic {S_EMPTY, S_FULL} rr_state_t; function rr_next_idx
//    (modulo increment); MAX_REQ=16 constant.
//  - Sub-module rr_priority_picker (req vector + last_grant -> winner index + any_valid), pure comb.
//  - Data select via existing parametric_mux (mem_width=DATA_W, mem_depth=NUM_REQ), addr=winner.
// TESTING
//  1. Reset: assert reset 2 cycles with all req_valid=1 -> req_ready=0, out_valid=0, out_data=0.
//  2. NUM_REQ=4, req_valid=4'b1111 constant, out_ready=1 -> out_id sequence 0,1,2,3,0 on 5 cycles.
//  3. req_valid=4'b1010, data1=0xAAAA0001, data3=0xBBBB0003 -> out_id 1 then 3, matching data.
//  4. out_valid=1, out_ready=0 for 3 cycles -> out_data/out_id stable, req_ready=0, last_grant unchanged.
//  5. Reset asserted while S_FULL, out_ready=0 -> next cycle out_valid=0, next grant goes to req 0.
//  6. LOCK_EN: req2 accepted with lock=1, req0/1 valid -> req2 sole grantee until lock=0 transfer,
//     then req3 scanned first (wraps to 0 if req3 idle).

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Optional lock feature elsewhere is enabled by defining RR_ARB_LOCK_EN.
package rr_arb_pkg;

   localparam int MAX_REQ = 16;
   localparam int IDX_W   = 4;

   typedef enum logic {S_EMPTY, S_FULL} rr_state_t;

   // Increment modulo n, so non-power-of-2 requester counts wrap correctly
   function automatic logic [IDX_W-1:0] rr_next_idx(
      input logic [IDX_W-1:0] idx,
      input int unsigned      n
   );
      if (32'(idx) + 32'd1 >= n) return '0;
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/parametric_mux.sv
// Generic N:1 word multiplexer over a packed word array.
// Word i sits at data[(i+1)*mem_width-1 : i*mem_width].
module parametric_mux #(
   parameter int mem_width = 32,
   parameter int mem_depth = 4,
   localparam int AW       = $clog2(mem_depth)
) (
   input  logic [mem_width*mem_depth-1:0] data,
   input  logic [AW-1:0]                  addr,
   output logic [mem_width-1:0]           q
);

   always_comb begin
      q = '0;
      for (int i = 0; i < mem_depth; i++) begin
         if (addr == AW'(i)) q = data[i*mem_width +: mem_width];
      end
   end

endmodule

// File: rtl/rr_priority_picker.sv
// Rotating-priority picker: first valid bit after last_grant, with wrap.
// Purely combinational; used by rr_mux_arbiter.
module rr_priority_picker
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    winner,
   output logic               any_valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = IDX_W'(last_grant);
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = rr_next_idx(idx, NUM_REQ);
         if (!any_valid && valid[idx[ID_W-1:0]]) begin
            any_valid = 1'b1;
            winner    = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding a one-entry registered output stage.
// Define RR_ARB_LOCK_EN to add the req_lock port and owner-lock behaviour.
module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
`ifdef RR_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [ID_W-1:0]           out_id
);

   rr_state_t            state;
   logic [ID_W-1:0]      last_grant;
   logic [ID_W-1:0]      winner;
   logic                 any_valid;
   logic                 can_accept;
   logic                 accept;
   logic [NUM_REQ-1:0]   eligible;
   logic [DATA_W-1:0]    sel_data;

`ifdef RR_ARB_LOCK_EN
   logic                 lock_active;
   logic [ID_W-1:0]      lock_owner;

   // While locked, only the owner may compete, even if it is idle
   always_comb begin
      eligible = req_valid;
      if (lock_active) begin
         eligible = '0;
         eligible[lock_owner] = req_valid[lock_owner];
      end
   end
`else
   assign eligible = req_valid;
`endif

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .valid      (eligible),
      .last_grant (last_grant),
      .winner     (winner),
      .any_valid  (any_valid)
   );

   parametric_mux #(
      .mem_width (DATA_W),
      .mem_depth (NUM_REQ)
   ) u_mux (
      .data (req_data),
      .addr (winner),
      .q    (sel_data)
   );

   assign can_accept = !reset && (state == S_EMPTY || out_ready);
   assign accept     = can_accept && any_valid;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   assign out_valid = (state == S_FULL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_EMPTY;
         out_data   <= '0;
         out_id     <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
`ifdef RR_ARB_LOCK_EN
         lock_active <= 1'b0;
         lock_owner  <= '0;
`endif
      end else if (accept) begin
         state      <= S_FULL;
         out_data   <= sel_data;
         out_id     <= winner;
         last_grant <= winner;
`ifdef RR_ARB_LOCK_EN
         lock_active <= req_lock[winner];
         lock_owner  <= winner;
`endif
      end else if (out_ready) begin
         state <= S_EMPTY;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (NUM_REQ=4, DATA_W=32).
// Lock scenario runs only when RR_ARB_LOCK_EN is defined.
module tb_rr_mux_arbiter;

   localparam int DATA_W  = 32;
   localparam int NUM_REQ = 4;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [DATA_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
`ifdef RR_ARB_LOCK_EN
   logic [NUM_REQ-1:0]        req_lock;
`endif
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [1:0]                out_id;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(
      .DATA_W  (DATA_W),
      .NUM_REQ (NUM_REQ)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
`ifdef RR_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_word(input int i, input logic [31:0] w);
      req_data[i*DATA_W +: DATA_W] = w;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      req_data  = '0;
`ifdef RR_ARB_LOCK_EN
      req_lock  = '0;
`endif
      for (int i = 0; i < NUM_REQ; i++) set_word(i, 32'h1000_0000 + 32'(i));

      // reset held two cycles with every requester asking
      tick();
      settle();
      chk("rst_ready0", 32'(req_ready), 32'h0);
      tick();
      settle();
      chk("rst_ready1", 32'(req_ready), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_id", 32'(out_id), 32'h0);

      // full round-robin rotation starting at requester 0
      reset = 1'b0;
      settle();
      chk("rr_first_ready", 32'(req_ready), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rr_id%0d", i), 32'(out_id), 32'(i % 4));
         chk($sformatf("rr_data%0d", i), out_data,
             32'h1000_0000 + 32'(i % 4));
         chk($sformatf("rr_valid%0d", i), 32'(out_valid), 32'h1);
      end

      // sparse requests 1 and 3 (last_grant is 0)
      set_word(1, 32'hAAAA_0001);
      set_word(3, 32'hBBBB_0003);
      req_valid = 4'b1010;
      tick();
      chk("sp_id1", 32'(out_id), 32'h1);
      chk("sp_data1", out_data, 32'hAAAA_0001);
      tick();
      chk("sp_id3", 32'(out_id), 32'h3);
      chk("sp_data3", out_data, 32'hBBBB_0003);

      // stall: output held, no grants, priority not rotated
      out_ready = 1'b0;
      req_valid = 4'b1111;
      settle();
      chk("st_ready", 32'(req_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("st_id%0d", i), 32'(out_id), 32'h3);
         chk($sformatf("st_data%0d", i), out_data, 32'hBBBB_0003);
         chk($sformatf("st_valid%0d", i), 32'(out_valid), 32'h1);
         chk($sformatf("st_rdy%0d", i), 32'(req_ready), 32'h0);
      end
      out_ready = 1'b1;
      settle();
      chk("st_release_ready", 32'(req_ready), 32'h1);
      tick();
      chk("st_release_id", 32'(out_id), 32'h0);

      // drain with no requests
      req_valid = 4'b0000;
      tick();
      chk("drain_valid", 32'(out_valid), 32'h0);
      tick();
      chk("idle_valid", 32'(out_valid), 32'h0);

      // reset while full and stalled
      req_valid = 4'b0100;
      tick();
      chk("pre_rst_id", 32'(out_id), 32'h2);
      req_valid = 4'b0000;
      out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      reset     = 1'b1;
      req_valid = 4'b1111;
      settle();
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", out_data, 32'h0);
      reset     = 1'b0;
      out_ready = 1'b1;
      settle();
      chk("post_rst_ready", 32'(req_ready), 32'h1);
      tick();
      chk("post_rst_id", 32'(out_id), 32'h0);

`ifdef RR_ARB_LOCK_EN
      // last_grant is 0; requester 2 takes a lock
      req_valid = 4'b0111;
      req_lock  = 4'b0100;
      settle();
      chk("lk_pre_ready", 32'(req_ready), 32'h2);
      req_valid = 4'b0100;
      tick();
      chk("lk_take_id", 32'(out_id), 32'h2);
      req_valid = 4'b0011;
      settle();
      chk("lk_owner_idle", 32'(req_ready), 32'h0);
      tick();
      chk("lk_idle_valid", 32'(out_valid), 32'h0);
      req_valid = 4'b0111;
      settle();
      chk("lk_owner_ready", 32'(req_ready), 32'h4);
      tick();
      chk("lk_hold_id", 32'(out_id), 32'h2);
      req_lock = 4'b0000;
      settle();
      chk("lk_release_ready", 32'(req_ready), 32'h4);
      tick();
      chk("lk_release_id", 32'(out_id), 32'h2);
      req_valid = 4'b1011;
      settle();
      chk("lk_after_req3", 32'(req_ready), 32'h8);
      req_valid = 4'b0011;
      settle();
      chk("lk_after_wrap", 32'(req_ready), 32'h1);
      tick();
      chk("lk_after_id", 32'(out_id), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
